// File: rtl/sync_f2s_hs_tx_if.sv
// Handshake bundle between a fast-domain producer, the f2s transmitter and the slow-domain receiver.
// The slave modport is the transmitter's view; master is the producer/receiver environment.
interface sync_f2s_hs_tx_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic             wr_en_i;
    logic [WIDTH-1:0] wr_data_i;
    logic             full_o;
    logic [LW-1:0]    level_o;
    logic             wr_err_o;
    logic             err_clr_i;
    logic             req_o;
    logic [WIDTH-1:0] data_o;
    logic             ack_i;
    logic             busy_o;

    modport slave (
        input  wr_en_i, wr_data_i, err_clr_i, ack_i,
        output full_o, level_o, wr_err_o, req_o, data_o, busy_o
    );

    modport master (
        output wr_en_i, wr_data_i, err_clr_i, ack_i,
        input  full_o, level_o, wr_err_o, req_o, data_o, busy_o
    );
endinterface

// File: rtl/sync_f2s_hs_tx.sv
// Fast-domain transmitter of a multi-bit req/ack synchroniser: FIFO in front of a
// 4-phase (MODE 0) or 2-phase toggle (MODE 1) launcher with a synchronised ack.
//
// state      | meaning
// S_IDLE     | no word in flight; launches head word when FIFO non-empty
// S_REQ      | MODE 0: req_o high, waiting for ack_s high
// S_WAIT_LOW | MODE 0: req_o low, waiting for ack_s to drop
// S_WAIT     | MODE 1: req_o toggled, waiting for ack_s == req_o
module sync_f2s_hs_tx #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int MODE        = 0
) (
    input  logic               clk_f,
    input  logic               rstn,
    sync_f2s_hs_tx_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REQ      = 2'd1,
        S_WAIT_LOW = 2'd2,
        S_WAIT     = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       mem_q [DEPTH];
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]          count_q, count_d;
    logic                   wr_err_q, wr_err_d;
    logic                   req_q, req_d;
    logic [WIDTH-1:0]       data_q, data_d;
    logic [SYNC_STAGES-1:0] ack_sync_q;

    logic ack_s;
    logic full;
    logic push;
    logic overflow;
    logic pop;

    assign ack_s    = ack_sync_q[SYNC_STAGES-1];
    assign full     = (count_q == LW'(DEPTH));
    assign push     = bus.wr_en_i && !full;
    assign overflow = bus.wr_en_i && full;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop    = 1'b1;
                    data_d = mem_q[rd_ptr_q];
                    if (MODE == 0) begin
                        req_d   = 1'b1;
                        state_d = S_REQ;
                    end else begin
                        req_d   = ~req_q;
                        state_d = S_WAIT;
                    end
                end
            end
            S_REQ: begin
                if (ack_s) begin
                    req_d   = 1'b0;
                    state_d = S_WAIT_LOW;
                end
            end
            S_WAIT_LOW: begin
                if (!ack_s) state_d = S_IDLE;
            end
            S_WAIT: begin
                if (ack_s == req_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Overflow is judged on the pre-edge count, so a same-cycle pop does not rescue it.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)      count_d = count_q + LW'(1);
        else if (!push && pop) count_d = count_q - LW'(1);
        wr_err_d = wr_err_q;
        if (overflow)           wr_err_d = 1'b1;
        else if (bus.err_clr_i) wr_err_d = 1'b0;
    end

    always_ff @(posedge clk_f or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wr_err_q   <= 1'b0;
            req_q      <= 1'b0;
            data_q     <= '0;
            ack_sync_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            wr_err_q   <= wr_err_d;
            req_q      <= req_d;
            data_q     <= data_d;
            ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], bus.ack_i};
        end
    end

    always_ff @(posedge clk_f) begin
        if (push) mem_q[wr_ptr_q] <= bus.wr_data_i;
    end

    assign bus.full_o   = full;
    assign bus.level_o  = count_q;
    assign bus.wr_err_o = wr_err_q;
    assign bus.req_o    = req_q;
    assign bus.data_o   = data_q;
    assign bus.busy_o   = (state_q != S_IDLE);
endmodule

// File: tb/tb_sync_f2s_hs_tx.sv
// Bench for sync_f2s_hs_tx: one MODE 0 and one MODE 1 instance, echo-ack receivers,
// and a queue scoreboard that tracks accepted words, launches and the error flag.
module tb_sync_f2s_hs_tx;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int SS    = 2;

    logic clk_f = 1'b0;
    logic rstn  = 1'b0;
    always #5 clk_f = ~clk_f;

    sync_f2s_hs_tx_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) if0 ();
    sync_f2s_hs_tx_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) if1 ();

    sync_f2s_hs_tx #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_STAGES(SS), .MODE(0)) dut0 (
        .clk_f(clk_f), .rstn(rstn), .bus(if0.slave));
    sync_f2s_hs_tx #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_STAGES(SS), .MODE(1)) dut1 (
        .clk_f(clk_f), .rstn(rstn), .bus(if1.slave));

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic g_req(int m);   return m ? if1.req_o    : if0.req_o;    endfunction
    function automatic logic g_busy(int m);  return m ? if1.busy_o   : if0.busy_o;   endfunction
    function automatic logic g_full(int m);  return m ? if1.full_o   : if0.full_o;   endfunction
    function automatic logic g_err(int m);   return m ? if1.wr_err_o : if0.wr_err_o; endfunction
    function automatic logic g_ack(int m);   return m ? if1.ack_i    : if0.ack_i;    endfunction
    function automatic logic g_wr_en(int m); return m ? if1.wr_en_i  : if0.wr_en_i;  endfunction
    function automatic logic g_clr(int m);   return m ? if1.err_clr_i : if0.err_clr_i; endfunction
    function automatic logic [2:0] g_level(int m); return m ? if1.level_o : if0.level_o; endfunction
    function automatic logic [7:0] g_data(int m);  return m ? if1.data_o  : if0.data_o;  endfunction
    function automatic logic [7:0] g_wdata(int m); return m ? if1.wr_data_i : if0.wr_data_i; endfunction

    task automatic set_ack(input int m, input logic v);
        if (m != 0) if1.ack_i = v; else if0.ack_i = v;
    endtask

    task automatic drv(input int m, input logic en, input logic [7:0] d, input logic clr);
        if (m != 0) begin if1.wr_en_i = en; if1.wr_data_i = d; if1.err_clr_i = clr; end
        else begin if0.wr_en_i = en; if0.wr_data_i = d; if0.err_clr_i = clr; end
    endtask

    // Inputs change 3 time units after the edge; the scoreboard samples at +2.
    task automatic step();
        @(posedge clk_f);
        #3;
    endtask

    // Receiver models: echo req_o onto ack_i after a fixed or random number of cycles.
    bit ack_en [2];
    int ack_fix [2];
    int pend [2];
    initial begin
        if0.ack_i = 1'b0;
        if1.ack_i = 1'b0;
        pend[0] = 0;
        pend[1] = 0;
        forever begin
            @(posedge clk_f);
            #1;
            for (int m = 0; m < 2; m++) begin
                if (!rstn) begin
                    set_ack(m, 1'b0);
                    pend[m] = 0;
                end else if (pend[m] > 0) begin
                    pend[m]--;
                    if (pend[m] == 0) set_ack(m, g_req(m));
                end else if (ack_en[m] && (g_req(m) !== g_ack(m))) begin
                    pend[m] = (ack_fix[m] > 0) ? ack_fix[m] : int'($urandom_range(1, 10));
                end
            end
        end
    end

    // Scoreboard: words accepted minus words launched is the queued level.
    int         acc [2];
    int         lau [2];
    logic       prev_req [2];
    logic       prev_ack [2];
    logic [7:0] prev_data [2];
    int         ack_stable [2];
    logic       exp_err [2];
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    logic [7:0] rx0 [$];
    logic [7:0] rx1 [$];

    function automatic int qsize(int m); return m ? q1.size() : q0.size(); endfunction

    initial begin
        forever begin
            @(posedge clk_f);
            #2;
            for (int m = 0; m < 2; m++) begin
                if (!rstn) begin
                    acc[m] = 0; lau[m] = 0;
                    prev_req[m] = 1'b0; prev_ack[m] = 1'b0; prev_data[m] = '0;
                    ack_stable[m] = SS; exp_err[m] = 1'b0;
                    if (m != 0) q1.delete(); else q0.delete();
                end else begin
                    int   lvl;
                    logic launch;
                    logic [7:0] front;
                    lvl = acc[m] - lau[m];
                    if (g_wr_en(m) && lvl < DEPTH) begin
                        acc[m]++;
                        if (m != 0) q1.push_back(g_wdata(m)); else q0.push_back(g_wdata(m));
                    end
                    if (g_wr_en(m) && lvl == DEPTH) exp_err[m] = 1'b1;
                    else if (g_clr(m))              exp_err[m] = 1'b0;
                    launch = (m != 0) ? (g_req(m) != prev_req[m]) : (g_req(m) && !prev_req[m]);
                    if (launch) begin
                        chk($sformatf("m%0d_launch_after_ack", m),
                            (g_ack(m) == prev_req[m]) && (ack_stable[m] >= SS), 1'b1);
                        chk($sformatf("m%0d_launch_has_word", m), qsize(m) != 0, 1'b1);
                        if (qsize(m) != 0) begin
                            front = (m != 0) ? q1.pop_front() : q0.pop_front();
                            chk($sformatf("m%0d_rx_order", m), g_data(m), front);
                        end
                        if (m != 0) rx1.push_back(g_data(m)); else rx0.push_back(g_data(m));
                        lau[m]++;
                    end else begin
                        chk($sformatf("m%0d_data_hold", m), g_data(m), prev_data[m]);
                    end
                    lvl = acc[m] - lau[m];
                    chk($sformatf("m%0d_level", m), g_level(m), lvl);
                    chk($sformatf("m%0d_full", m), g_full(m), lvl == DEPTH);
                    chk($sformatf("m%0d_wr_err", m), g_err(m), exp_err[m]);
                    if (g_ack(m) != prev_ack[m]) ack_stable[m] = 0;
                    else ack_stable[m]++;
                    prev_ack[m]  = g_ack(m);
                    prev_req[m]  = g_req(m);
                    prev_data[m] = g_data(m);
                end
            end
        end
    end

    task automatic drain(input int m, input string tag);
        int n;
        n = 0;
        while ((g_busy(m) || g_level(m) != 0) && n < 2000) begin
            step();
            n++;
        end
        chk({tag, "_drained"}, (g_busy(m) == 1'b0) && (g_level(m) == 0), 1'b1);
        chk({tag, "_queue_empty"}, qsize(m), 0);
    endtask

    initial begin
        int n, ack_edge, fall_edge, ack_low_edge, idle_edge, s0, s1;
        for (int m = 0; m < 2; m++) begin
            drv(m, 1'b0, 8'h00, 1'b0);
            ack_en[m]  = 1'b0;
            ack_fix[m] = 3;
        end
        repeat (3) @(posedge clk_f);
        #3;
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("m%0d_rst_req", m),   g_req(m),   1'b0);
            chk($sformatf("m%0d_rst_data", m),  g_data(m),  8'h00);
            chk($sformatf("m%0d_rst_err", m),   g_err(m),   1'b0);
            chk($sformatf("m%0d_rst_level", m), g_level(m), 0);
            chk($sformatf("m%0d_rst_full", m),  g_full(m),  1'b0);
            chk($sformatf("m%0d_rst_busy", m),  g_busy(m),  1'b0);
        end
        rstn = 1'b1;
        step();

        // Single word, MODE 0, ack echoes after 3 cycles.
        ack_en[0] = 1'b1;
        drv(0, 1'b1, 8'hA5, 1'b0);
        step();
        drv(0, 1'b0, 8'h00, 1'b0);
        chk("t1_level_after_push", if0.level_o, 1);
        chk("t1_req_not_yet", if0.req_o, 1'b0);
        step();
        chk("t1_req_launch", if0.req_o, 1'b1);
        chk("t1_data_launch", if0.data_o, 8'hA5);
        chk("t1_level_after_launch", if0.level_o, 0);
        chk("t1_busy", if0.busy_o, 1'b1);
        n = 0; ack_edge = -1; fall_edge = -1;
        while (n < 40 && fall_edge < 0) begin
            step();
            n++;
            if (ack_edge < 0 && if0.ack_i) ack_edge = n;
            if (!if0.req_o) fall_edge = n;
            chk("t1_data_hold_req", if0.data_o, 8'hA5);
        end
        chk("t1_req_fell", if0.req_o, 1'b0);
        // ack_i changes between edges; it is first sampled at ack_edge+1.
        chk("t1_req_fall_delay", fall_edge - (ack_edge + 1), SS);
        n = 0; ack_low_edge = -1; idle_edge = -1;
        while (n < 40 && idle_edge < 0) begin
            step();
            n++;
            if (ack_low_edge < 0 && !if0.ack_i) ack_low_edge = n;
            if (!if0.busy_o) idle_edge = n;
            if (if0.busy_o) chk("t1_data_hold_wait", if0.data_o, 8'hA5);
        end
        chk("t1_busy_fell", if0.busy_o, 1'b0);
        chk("t1_busy_fall_delay", idle_edge - (ack_low_edge + 1), SS);
        chk("t1_level_end", if0.level_o, 0);

        // DEPTH+1 words back-to-back with the receiver stalled, then one overflow.
        ack_en[0] = 1'b0;
        rx0.delete();
        for (int i = 1; i <= 6; i++) begin
            drv(0, 1'b1, 8'(i), 1'b0);
            step();
        end
        drv(0, 1'b0, 8'h00, 1'b0);
        chk("t2_level_full", if0.level_o, DEPTH);
        chk("t2_full", if0.full_o, 1'b1);
        chk("t2_wr_err", if0.wr_err_o, 1'b1);
        chk("t2_data_first", if0.data_o, 8'h01);
        ack_fix[0] = 0;
        ack_en[0]  = 1'b1;
        drain(0, "t2");
        chk("t2_rx_count", rx0.size(), 5);
        for (int i = 0; i < 5 && i < rx0.size(); i++)
            chk($sformatf("t2_rx%0d", i), rx0[i], 8'(i + 1));
        drv(0, 1'b0, 8'h00, 1'b1);
        step();
        drv(0, 1'b0, 8'h00, 1'b0);
        chk("t2_err_cleared", if0.wr_err_o, 1'b0);

        // MODE 1: three words, toggle echo.
        ack_en[1] = 1'b1;
        rx1.delete();
        drv(1, 1'b1, 8'h10, 1'b0); step();
        drv(1, 1'b1, 8'h20, 1'b0); step();
        drv(1, 1'b1, 8'h30, 1'b0); step();
        drv(1, 1'b0, 8'h00, 1'b0);
        drain(1, "t3");
        chk("t3_rx_count", rx1.size(), 3);
        if (rx1.size() == 3) begin
            chk("t3_rx0", rx1[0], 8'h10);
            chk("t3_rx1", rx1[1], 8'h20);
            chk("t3_rx2", rx1[2], 8'h30);
        end
        chk("t3_req_final", if1.req_o, 1'b1);

        // Overflow and err_clr in the same cycle: set wins.
        ack_en[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drv(0, 1'b1, 8'(8'h40 + i), 1'b0);
            step();
        end
        drv(0, 1'b1, 8'h45, 1'b1);
        step();
        chk("t4_err_set_wins", if0.wr_err_o, 1'b1);
        drv(0, 1'b0, 8'h00, 1'b1);
        step();
        chk("t4_err_clear", if0.wr_err_o, 1'b0);
        drv(0, 1'b0, 8'h00, 1'b0);
        step();
        chk("t4_err_stays_clear", if0.wr_err_o, 1'b0);
        ack_en[0] = 1'b1;
        drain(0, "t4");

        // Reset while in REQ with two words queued.
        ack_en[0] = 1'b0;
        drv(0, 1'b1, 8'h50, 1'b0); step();
        drv(0, 1'b1, 8'h51, 1'b0); step();
        drv(0, 1'b1, 8'h52, 1'b0); step();
        drv(0, 1'b0, 8'h00, 1'b0);
        chk("t5_pre_level", if0.level_o, 2);
        chk("t5_pre_req", if0.req_o, 1'b1);
        #1 rstn = 1'b0;
        #1;
        chk("t5_rst_req", if0.req_o, 1'b0);
        chk("t5_rst_level", if0.level_o, 0);
        chk("t5_rst_busy", if0.busy_o, 1'b0);
        chk("t5_rst_data", if0.data_o, 8'h00);
        repeat (2) @(posedge clk_f);
        #3 rstn = 1'b1;
        ack_en[0] = 1'b1;
        rx0.delete();
        drv(0, 1'b1, 8'h7E, 1'b0);
        step();
        drv(0, 1'b0, 8'h00, 1'b0);
        step();
        chk("t5_relaunch_req", if0.req_o, 1'b1);
        chk("t5_relaunch_data", if0.data_o, 8'h7E);
        drain(0, "t5");
        chk("t5_rx_count", rx0.size(), 1);

        // Random traffic, random ack delay, both modes, 200 accepted words each.
        ack_fix[0] = 0;
        ack_fix[1] = 0;
        ack_en[1]  = 1'b1;
        s0 = acc[0];
        s1 = acc[1];
        n = 0;
        while ((acc[0] - s0 < 200 || acc[1] - s1 < 200) && n < 30000) begin
            drv(0, (acc[0] - s0 < 200) && ($urandom_range(0, 3) != 0), 8'($urandom), $urandom_range(0, 15) == 0);
            drv(1, (acc[1] - s1 < 200) && ($urandom_range(0, 3) != 0), 8'($urandom), $urandom_range(0, 15) == 0);
            step();
            n++;
        end
        drv(0, 1'b0, 8'h00, 1'b0);
        drv(1, 1'b0, 8'h00, 1'b0);
        chk("t6_m0_words", acc[0] - s0 >= 200, 1'b1);
        chk("t6_m1_words", acc[1] - s1 >= 200, 1'b1);
        drain(0, "t6_m0");
        drain(1, "t6_m1");
        chk("t6_m0_launched", lau[0], acc[0]);
        chk("t6_m1_launched", lau[1], acc[1]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
